// File: rtl/ev22_sequencer.sv
// EV22 multi-cycle control sequencer: fetch over req/ack, give the decoder a cycle,
// then issue PC update, optional data access and write-back strobes.
module ev22_sequencer #(
  parameter int PC_W  = 16,
  parameter int TMO   = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic [6:0]       itype,     // decoder instruction class ("type")
  input  logic             mr,
  input  logic             mw,
  input  logic             branch_taken,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             w_we,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tmo;

  // PC width and the ALU/spare class bits carry no function in this block.
  logic [PC_W-1:0]  w_pcw_unused;
  logic             w_unused;
  assign w_pcw_unused = '0;
  assign w_unused     = ^{itype[5:3], w_pcw_unused};

  // Counter holds the number of ackless cycles so far; ack takes priority over timeout.
  assign w_tmo       = (r_wait == 8'(TMO - 1));
  assign instr_count = r_cnt;

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    w_we     = 1'b0;
    halted   = 1'b0;
    bus_err  = 1'b0;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          w_next  = S_DECODE;
        end else if (w_tmo) begin
          w_next = S_ERR;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (mr && mw) begin
          w_next = S_ERR;
        end else begin
          if (itype[2] && branch_taken) pc_load = 1'b1;
          else                          pc_inc  = 1'b1;
          w_next = (mr || mw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mw;
        if (dmem_ack)   w_next = S_WB;
        else if (w_tmo) w_next = S_ERR;
      end
      S_WB: begin
        rf_we = itype[0];
        w_we  = itype[1];
        if (itype[6]) w_next = S_HALT;
        else if (run) w_next = S_FETCH;
        else          w_next = S_IDLE;
      end
      S_HALT:   halted  = 1'b1;
      S_ERR:    bus_err = 1'b1;
      default:  w_next  = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM)
        r_wait <= r_wait + 8'd1;
      if (r_state == S_WB)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ev22_sequencer.sv
// Directed bench for ev22_sequencer: inputs change and outputs are checked at the falling edge.
module tb_ev22_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, mr, mw, branch_taken, dmem_ack;
  logic [6:0]  itype;
  logic        imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we;
  logic        rf_we, w_we, halted, bus_err;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;

  ev22_sequencer #(.PC_W(16), .TMO(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .itype(itype), .mr(mr), .mw(mw), .branch_taken(branch_taken),
    .pc_inc(pc_inc), .pc_load(pc_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .w_we(w_we), .halted(halted), .bus_err(bus_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    mr = 1'b0; mw = 1'b0; branch_taken = 1'b0; itype = 7'd0;

    // Reset state
    cyc; #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_count", instr_count, 0);

    // W=K, immediate fetch ack: pc_inc cycle 3, w_we cycle 4
    cyc; rst_n = 1'b1; run = 1'b1; #1;
    chk("t1_idle_req", imem_req, 0);
    cyc; imem_ack = 1'b1; itype = 7'b0000010; #1;
    chk("t1_fetch_req", imem_req, 1);
    chk("t1_ir_load", ir_load, 1);
    cyc; imem_ack = 1'b0; #1;
    chk("t1_dec_ir_load", ir_load, 0);
    chk("t1_dec_pc_inc", pc_inc, 0);
    cyc; #1;
    chk("t1_exec_pc_inc", pc_inc, 1);
    chk("t1_exec_pc_load", pc_load, 0);
    chk("t1_exec_w_we", w_we, 0);
    cyc; run = 1'b0; #1;
    chk("t1_wb_w_we", w_we, 1);
    chk("t1_wb_rf_we", rf_we, 0);
    chk("t1_wb_count", instr_count, 0);
    cyc; #1;
    chk("t1_count", instr_count, 1);
    chk("t1_idle_req2", imem_req, 0);

    // Ri=W with fetch ack delayed 3 cycles: rf_we in cycle 7
    cyc; run = 1'b1; itype = 7'b0001001; #1;
    for (int i = 0; i < 3; i++) begin
      cyc; #1;
      chk("t2_wait_req", imem_req, 1);
      chk("t2_wait_ir_load", ir_load, 0);
    end
    cyc; imem_ack = 1'b1; #1;
    chk("t2_ir_load", ir_load, 1);
    cyc; imem_ack = 1'b0; #1;
    cyc; #1;
    chk("t2_exec_pc_inc", pc_inc, 1);
    cyc; #1;
    chk("t2_wb_rf_we", rf_we, 1);
    chk("t2_wb_w_we", w_we, 0);

    // Memory write, dmem ack on third MEM cycle (run still high: back-to-back fetch)
    cyc; imem_ack = 1'b1; itype = 7'd0; mw = 1'b1; #1;
    chk("t3_ir_load", ir_load, 1);
    cyc; imem_ack = 1'b0; #1;
    cyc; #1;
    chk("t3_exec_pc_inc", pc_inc, 1);
    chk("t3_exec_dmem_req", dmem_req, 0);
    for (int i = 0; i < 2; i++) begin
      cyc; #1;
      chk("t3_mem_req", dmem_req, 1);
      chk("t3_mem_we", dmem_we, 1);
    end
    cyc; dmem_ack = 1'b1; #1;
    chk("t3_mem_req_ack", dmem_req, 1);
    chk("t3_mem_we_ack", dmem_we, 1);
    cyc; dmem_ack = 1'b0; #1;
    chk("t3_wb_dmem_req", dmem_req, 0);
    chk("t3_wb_count", instr_count, 2);

    // Taken branch: pc_load only
    cyc; mw = 1'b0; imem_ack = 1'b1; itype = 7'b0000100; branch_taken = 1'b1; #1;
    cyc; imem_ack = 1'b0; #1;
    cyc; #1;
    chk("t4_pc_load", pc_load, 1);
    chk("t4_pc_inc", pc_inc, 0);
    cyc; run = 1'b0; #1;
    chk("t4_wb_rf_we", rf_we, 0);
    cyc; #1;
    chk("t4_count", instr_count, 4);
    chk("t4_idle_req", imem_req, 0);

    // Memory read with ack withheld: error after 15 wait cycles, sticky
    cyc; run = 1'b1; mr = 1'b1; itype = 7'd0; branch_taken = 1'b0; #1;
    cyc; imem_ack = 1'b1; #1;
    cyc; imem_ack = 1'b0; #1;
    cyc; #1;
    for (int i = 0; i < 15; i++) begin
      cyc; #1;
      chk("t5_mem_req", dmem_req, 1);
      chk("t5_mem_we", dmem_we, 0);
      chk("t5_no_err_yet", bus_err, 0);
    end
    cyc; #1;
    chk("t5_bus_err", bus_err, 1);
    chk("t5_err_dmem_req", dmem_req, 0);
    for (int i = 0; i < 3; i++) begin
      cyc; run = ~run; imem_ack = 1'b1; dmem_ack = 1'b1; #1;
      chk("t5_err_sticky", bus_err, 1);
      chk("t5_err_imem_req", imem_req, 0);
    end
    cyc; rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; #1;
    chk("t5_rst_err", bus_err, 0);
    chk("t5_rst_count", instr_count, 0);

    // Same read, ack on exactly the 15th MEM cycle: no error
    cyc; rst_n = 1'b1; run = 1'b1; mr = 1'b1; #1;
    cyc; imem_ack = 1'b1; #1;
    cyc; imem_ack = 1'b0; #1;
    cyc; #1;
    for (int i = 0; i < 14; i++) begin
      cyc; #1;
    end
    cyc; dmem_ack = 1'b1; #1;
    chk("t6_mem_req_15", dmem_req, 1);
    cyc; dmem_ack = 1'b0; run = 1'b0; #1;
    chk("t6_wb_no_err", bus_err, 0);
    cyc; #1;
    chk("t6_no_err", bus_err, 0);
    chk("t6_count", instr_count, 1);

    // mr and mw together: ERR with no PC pulse
    cyc; run = 1'b1; mr = 1'b1; mw = 1'b1; #1;
    cyc; imem_ack = 1'b1; #1;
    cyc; imem_ack = 1'b0; #1;
    cyc; #1;
    chk("t7_pc_inc", pc_inc, 0);
    chk("t7_pc_load", pc_load, 0);
    cyc; #1;
    chk("t7_bus_err", bus_err, 1);
    chk("t7_dmem_req", dmem_req, 0);
    cyc; rst_n = 1'b0; run = 1'b0; mr = 1'b0; mw = 1'b0; #1;

    // Halt: sticky, run toggles cause no fetch
    cyc; rst_n = 1'b1; run = 1'b1; itype = 7'b1000000; #1;
    cyc; imem_ack = 1'b1; #1;
    cyc; imem_ack = 1'b0; #1;
    cyc; #1;
    chk("t8_exec_pc_inc", pc_inc, 1);
    cyc; #1;
    chk("t8_wb_rf_we", rf_we, 0);
    chk("t8_wb_halted", halted, 0);
    cyc; #1;
    chk("t8_halted", halted, 1);
    chk("t8_count", instr_count, 1);
    for (int i = 0; i < 4; i++) begin
      cyc; run = ~run; imem_ack = 1'b1; #1;
      chk("t8_no_fetch", imem_req, 0);
      chk("t8_halt_sticky", halted, 1);
    end
    cyc; rst_n = 1'b0; imem_ack = 1'b0; run = 1'b0; itype = 7'd0; #1;
    chk("t8_rst_halted", halted, 0);

    // Reset during MEM drops the request immediately
    cyc; rst_n = 1'b1; run = 1'b1; mw = 1'b1; #1;
    cyc; imem_ack = 1'b1; #1;
    cyc; imem_ack = 1'b0; #1;
    cyc; #1;
    cyc; #1;
    chk("t9_mem_req", dmem_req, 1);
    #1; rst_n = 1'b0; #1;
    chk("t9_rst_dmem_req", dmem_req, 0);
    chk("t9_rst_dmem_we", dmem_we, 0);
    cyc; rst_n = 1'b1; run = 1'b0; mw = 1'b0; #1;
    chk("t9_idle_req", imem_req, 0);
    cyc; #1;
    chk("t9_idle_req2", imem_req, 0);
    chk("t9_count", instr_count, 0);

    // Drop run in EXEC: instruction completes, then IDLE; stray dmem_ack in FETCH ignored
    cyc; run = 1'b1; itype = 7'b0000010; #1;
    cyc; imem_ack = 1'b1; dmem_ack = 1'b1; #1;
    chk("t10_fetch_dmem_req", dmem_req, 0);
    cyc; imem_ack = 1'b0; dmem_ack = 1'b0; #1;
    cyc; run = 1'b0; #1;
    chk("t10_exec_pc_inc", pc_inc, 1);
    cyc; #1;
    chk("t10_wb_w_we", w_we, 1);
    cyc; #1;
    chk("t10_idle_req", imem_req, 0);
    chk("t10_count", instr_count, 1);
    cyc; #1;
    chk("t10_idle_req2", imem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ev22_sequencer.md
# ev22_sequencer

Multi-cycle control FSM for the EV22 core. It fetches each instruction over a req/ack handshake and latches it into the instruction register. It then gives the combinational opcode decoder one cycle to settle, and uses the decoder's `type`, `mr` and `mw` outputs to sequence PC update, the optional data-memory access and register/W write-back. It sits between the instruction/data memory ports and the datapath enables, and is the only source of datapath write strobes.

## Interface
Parameters:
- `PC_W`, 16: reserved for PC-width-dependent checks; no functional effect in this block.
- `TMO`, 15: maximum wait cycles for any memory ack before bus error (1..255).
- `CNT_W`, 16: width of retired-instruction counter.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; start or continue execution.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch data valid this cycle.
- `ir_load`  out  1  one-cycle pulse; latch OPCODE/Ri into IR.
- `type`  in  7  decoder instruction class. Bit 0 = register-file write, bit 1 = W write, bit 2 = branch, bit 3 = ALU op, bit 6 = halt.
- `mr`  in  1  decoder memory read.
- `mw`  in  1  decoder memory write.
- `branch_taken`  in  1  datapath branch condition.
- `pc_inc`  out  1  one-cycle PC+1 pulse.
- `pc_load`  out  1  one-cycle PC load pulse.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  write qualifier, valid while `dmem_req`.
- `dmem_ack`  in  1  data access complete this cycle.
- `rf_we`  out  1  register-file write enable, one cycle.
- `w_we`  out  1  W register write enable, one cycle.
- `halted`  out  1  sticky halt status.
- `bus_err`  out  1  sticky error status.
- `instr_count`  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR. Reset state is IDLE.
- **Reset values:** all outputs 0 and `instr_count` = 0. Reset is effective immediately, including mid-access; no pending request survives it.
- **IDLE:** outputs 0. Moves to FETCH when `run`=1.
- **FETCH:** `imem_req`=1.
  - On `imem_ack`: `ir_load`=1 that same cycle, then go to DECODE.
  - A wait counter increments each cycle without ack. When it reaches TMO, go to ERR.
- **DECODE:** no strobes. The decoder settles from the IR; go to EXEC.
- **EXEC:** samples `type`, `mr`, `mw` and `branch_taken`.
  - If `type[2]` and `branch_taken`: `pc_load`=1. Otherwise: `pc_inc`=1. Exactly one of the two pulses fires.
  - If `mr` and `mw` are both 1: go to ERR. No PC pulse fires in this case.
  - Else if `mr` or `mw`: go to MEM.
  - Else: go to WB.
- **MEM:** `dmem_req`=1 and `dmem_we`=`mw`; both held stable until ack.
  - On `dmem_ack`: go to WB.
  - Uses the same TMO wait counter, cleared on entry; on timeout go to ERR.
- **WB:** `rf_we`=`type[0]` and `w_we`=`type[1]`, and `instr_count` increments.
  - If `type[6]`: go to HALT.
  - Else if `run`: go to FETCH.
  - Else: go to IDLE.
- **Unknown or undecoded opcodes:** `type`=0 executes as a NOP (pc_inc, no writes, counted).
- **`run` deasserted mid-instruction:** the current instruction completes through WB, then the FSM enters IDLE.
- **HALT:** `halted`=1. Terminal until reset; `run` is ignored.
- **ERR:** `bus_err`=1. Terminal until reset; all strobes stay 0.

## Timing
- Fetch with ack in its first cycle: FETCH→DECODE→EXEC→WB gives 4 cycles per non-memory instruction, and 5 cycles per memory instruction with ack in the first MEM cycle.
- Each wait cycle adds 1 cycle.
- Ack arriving in the same cycle the counter reaches TMO: the ack wins and there is no error.
- `ir_load`, `pc_inc`, `pc_load`, `rf_we` and `w_we` are single-cycle pulses decoded from state, plus the registered conditions above. They never overlap across different instructions.
- `type`/`mr`/`mw` must be stable from DECODE through WB. The IR is not reloaded until the next FETCH.
- Acks received outside FETCH/MEM are ignored.

## Test plan
- Reset, then `run`=1 with imem_ack immediate and `type`=7'b0000010 (W=K) → `w_we` pulses in cycle 4, `pc_inc` pulses in cycle 3, and `instr_count`=1.
- Ri=W (`type`=7'b0001001) with imem_ack delayed 3 cycles → `rf_we`=1 in cycle 7 and `w_we`=0.
- `mw`=1, dmem_ack after 2 cycles → `dmem_req` and `dmem_we` held for 3 cycles, then WB and count +1. Separately, `mr`=`mw`=1 → ERR with no PC pulse.
- dmem_ack withheld with TMO=15 → `bus_err` rises after 15 wait cycles and remains set. Repeat with ack on exactly the 15th cycle → no error.
- Branch with `branch_taken`=1 → `pc_load` pulse and no `pc_inc`. With `type[6]`=1 → `halted`=1, and later `run` toggles cause no fetch.
- Assert `rst_n` low during MEM → `dmem_req`=0 immediately and IDLE on release. Drop `run` mid-EXEC → instruction completes, then IDLE with `imem_req`=0.
